// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file debug dump reader.
package regfile_dump_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } dump_state_t;

    // Index tag carried by the trailing checksum word.
    localparam logic [3:0] CSUM_IDX = 4'hF;

endpackage

// File: rtl/regfile_dump.sv
// Debug reader for the register file: walks read addresses 0..NUM_REGS-1 on one
// read port after a start pulse and streams each captured word out on a
// valid/ready interface together with its index.
// Optional feature macro: REGFILE_DUMP_CSUM_EN -- when defined, one extra word
// (XOR of all captured words, index 4'hF) follows the last register.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [3:0]        r_out_idx;
`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_W-1:0] r_csum;
`endif

    // FSM, read-address counter, output word capture and checksum accumulator.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rd_addr <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
                        r_csum    <= '0;
`endif
                        r_state   <= READ;
                    end
                end
                // Sample the word now; a write landing on this same edge is
                // not visible, so the pre-write value is what gets sent.
                READ: begin
                    r_out_data  <= rd_data;
                    r_out_idx   <= 4'(r_rd_addr);
                    r_out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CSUM_EN
                    r_csum      <= r_csum ^ rd_data;
`endif
                    r_state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_rd_addr == LAST_ADDR) begin
`ifdef REGFILE_DUMP_CSUM_EN
                            r_state <= CSUM;
`else
                            r_state <= DONE;
`endif
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_state   <= READ;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CSUM_EN
                // First cycle loads the checksum word, then it is held until taken.
                CSUM: begin
                    if (!r_out_valid) begin
                        r_out_data  <= r_csum;
                        r_out_idx   <= CSUM_IDX;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= DONE;
                    end
                end
`endif
                // Single-cycle completion; start arriving here is dropped.
                DONE: begin
                    r_rd_addr <= '0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output decode: busy spans READ..DONE, done marks the DONE cycle.
    always_comb begin
        rd_addr   = r_rd_addr;
        out_valid = r_out_valid;
        out_data  = r_out_data;
        out_idx   = r_out_idx;
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
    end

endmodule
